// File: rtl/peb_sparse_expand_pkg.sv
// Shared types and helpers for the sparse activation expander.
package peb_sparse_expand_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EXP  = 1'b1
   } state_t;

   // Ceiling log2, used for popcount/rank and chunk index widths.
   function automatic int c_log_2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // Number of LANES-wide chunks in one flag word.
   function automatic int chunks(input int flag_width, input int lanes);
      return flag_width / lanes;
   endfunction

endpackage

// File: rtl/peb_zero_insert.sv
// Combinational rank/mux network: packed non-zero entries from the FIFO
// window are spread back out to the lanes selected by the mask; unselected
// lanes read zero. k is the number of window entries consumed.
module peb_zero_insert
   import peb_sparse_expand_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int LANES      = 4,
   localparam int CW        = c_log_2(LANES) + 1
) (
   input  logic [LANES-1:0]            mask,
   input  logic [DATA_WIDTH*LANES-1:0] win,
   output logic [DATA_WIDTH*LANES-1:0] dense,
   output logic [CW-1:0]               k
);

   // Running rank: each set mask bit takes the next packed window entry.
   always_comb begin
      logic [CW-1:0] rank;
      rank  = '0;
      dense = '0;
      for (int j = 0; j < LANES; j++) begin
         if (mask[j]) begin
            dense[DATA_WIDTH*j +: DATA_WIDTH] = win[DATA_WIDTH*rank +: DATA_WIDTH];
            rank = rank + CW'(1);
         end
      end
      k = rank;
   end

endmodule

// File: rtl/peb_sparse_expand.sv
// Sparse activation expander: one flag word per visit to IDLE, then one
// dense beat per chunk, popping only the non-zero entries from the FIFO.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | waiting for a flag word; pops and latches it when present
//   ST_EXP  | emitting one beat per chunk of the latched flag word
module peb_sparse_expand
   import peb_sparse_expand_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int LANES      = 4,
   parameter int FLAG_WIDTH = 16,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        Reset,
   input  logic                        flag_empty,
   input  logic [FLAG_WIDTH-1:0]       flag_data,
   output logic                        flag_pop,
   input  logic [DATA_WIDTH*LANES-1:0] dat_win,
   input  logic [ADDR_WIDTH:0]         dat_count,
   output logic                        dat_pop,
   output logic [ADDR_WIDTH-1:0]       dat_pop_offset,
   output logic [DATA_WIDTH*LANES-1:0] out_data,
   output logic                        out_valid,
   output logic                        out_last,
   input  logic                        out_ready
);

   localparam int CHUNKS = chunks(FLAG_WIDTH, LANES);
   localparam int CW     = c_log_2(LANES) + 1;
   localparam int IW     = (CHUNKS > 1) ? c_log_2(CHUNKS) : 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(CHUNKS - 1);

   state_t                      state, state_nxt;
   logic [IW-1:0]               idx, idx_nxt;
   logic [FLAG_WIDTH-1:0]       flag_reg;
   logic [LANES-1:0]            chunk;
   logic [DATA_WIDTH*LANES-1:0] dense;
   logic [CW-1:0]               k;
   logic [ADDR_WIDTH-1:0]       k_ext;
   logic                        in_rst;
   logic                        can_out;
   logic                        fire;
   logic                        flag_take;

   // Pops are suppressed whenever either reset is active so the FIFOs never
   // see a request from a state that is about to be discarded.
   assign in_rst    = !rst_n || Reset;
   assign chunk     = flag_reg[idx*LANES +: LANES];
   assign k_ext     = ADDR_WIDTH'(k);
   assign can_out   = !out_valid || out_ready;
   assign fire      = !in_rst && (state == ST_EXP) && can_out &&
                      (dat_count >= {1'b0, k_ext});
   assign flag_take = !in_rst && (state == ST_IDLE) && !flag_empty;

   assign flag_pop       = flag_take;
   assign dat_pop        = fire && (k != '0);
   assign dat_pop_offset = dat_pop ? k_ext : '0;

   peb_zero_insert #(
      .DATA_WIDTH (DATA_WIDTH),
      .LANES      (LANES)
   ) u_zero_insert (
      .mask  (chunk),
      .win   (dat_win),
      .dense (dense),
      .k     (k)
   );

   // Next-state and chunk index.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      case (state)
         ST_IDLE: begin
            if (flag_take) begin
               state_nxt = ST_EXP;
               idx_nxt   = '0;
            end
         end
         ST_EXP: begin
            if (fire) begin
               if (idx == IDX_LAST) begin
                  idx_nxt   = '0;
                  state_nxt = ST_IDLE;
               end else begin
                  idx_nxt = idx + IW'(1);
               end
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            idx_nxt   = '0;
         end
      endcase
   end

   // State register and chunk index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         idx   <= '0;
      end else if (Reset) begin
         state <= ST_IDLE;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
      end
   end

   // Flag latch and output beat register with valid/ready hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flag_reg  <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else if (Reset) begin
         flag_reg  <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else begin
         if (flag_take) flag_reg <= flag_data;
         if (fire) begin
            out_data  <= dense;
            out_valid <= 1'b1;
            out_last  <= (idx == IDX_LAST);
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_peb_sparse_expand.sv
// Scoreboard bench for peb_sparse_expand: a queue-based FIFO model feeds the
// DUT, expected beats and pop offsets are queued when a word is issued, and
// a negedge monitor checks everything the DUT presents.
module tb_peb_sparse_expand;

   localparam int DW = 8;
   localparam int L  = 4;
   localparam int FW = 16;
   localparam int AW = 4;
   localparam int CH = FW / L;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          Reset;
   logic          flag_empty;
   logic [FW-1:0] flag_data;
   logic          flag_pop;
   logic [DW*L-1:0] dat_win;
   logic [AW:0]   dat_count;
   logic          dat_pop;
   logic [AW-1:0] dat_pop_offset;
   logic [DW*L-1:0] out_data;
   logic          out_valid;
   logic          out_last;
   logic          out_ready;

   always #5 clk = ~clk;

   peb_sparse_expand #(
      .DATA_WIDTH (DW),
      .LANES      (L),
      .FLAG_WIDTH (FW),
      .ADDR_WIDTH (AW)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .Reset          (Reset),
      .flag_empty     (flag_empty),
      .flag_data      (flag_data),
      .flag_pop       (flag_pop),
      .dat_win        (dat_win),
      .dat_count      (dat_count),
      .dat_pop        (dat_pop),
      .dat_pop_offset (dat_pop_offset),
      .out_data       (out_data),
      .out_valid      (out_valid),
      .out_last       (out_last),
      .out_ready      (out_ready)
   );

   typedef struct {
      logic [DW*L-1:0] data;
      logic            last;
      logic            first;
   } beat_t;

   beat_t         exp_q[$];
   int            pop_q[$];
   logic [FW-1:0] flag_q[$];
   logic [DW-1:0] data_q[$];
   logic [DW-1:0] fixed_d[$];

   int tests = 0, fails = 0, cyc = 0, beats_seen = 0, total_popped = 0;
   int last_flag_pop_cyc = -1, first_beat_cyc = -1, last_dat_pop_cyc = -1;
   int count_cap = 1000;
   int ready_mode = 0, ready_ph = 0;
   bit req_flag_pop = 0;
   int req_dat_n = 0;
   bit stall_prev = 0;
   logic [DW*L-1:0] prev_data;
   logic            prev_last;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference: walk the flag bits lane by lane, filling set lanes from the
   // word's packed data in order; each non-empty chunk expects one pop.
   task automatic push_word(input logic [FW-1:0] f, input bit use_fixed);
      logic [DW-1:0] d[$];
      beat_t b;
      int ptr, kk;
      ptr = 0;
      for (int i = 0; i < FW; i++) begin
         if (f[i]) begin
            if (use_fixed) begin
               d.push_back(fixed_d[ptr]);
               ptr++;
            end else begin
               d.push_back(DW'($urandom));
            end
         end
      end
      ptr = 0;
      for (int c = 0; c < CH; c++) begin
         b.data  = '0;
         b.last  = (c == CH - 1);
         b.first = (c == 0);
         kk = 0;
         for (int j = 0; j < L; j++) begin
            if (f[c*L + j]) begin
               b.data[DW*j +: DW] = d[ptr];
               ptr++;
               kk++;
            end
         end
         exp_q.push_back(b);
         if (kk != 0) pop_q.push_back(kk);
      end
      foreach (d[i]) data_q.push_back(d[i]);
      flag_q.push_back(f);
   endtask

   task automatic drive_fifo();
      int n;
      n = data_q.size();
      if (n > count_cap) n = count_cap;
      if (n > 16) n = 16;
      dat_count = (AW+1)'(n);
      for (int j = 0; j < L; j++)
         dat_win[DW*j +: DW] = (j < n) ? data_q[j] : 8'hEE;
      flag_empty = (flag_q.size() == 0);
      flag_data  = flag_empty ? FW'($urandom) : flag_q[0];
   endtask

   // FIFO model: apply the pops the monitor saw, then present the new head.
   always begin
      @(posedge clk);
      #1;
      if (req_flag_pop && flag_q.size() > 0) void'(flag_q.pop_front());
      for (int i = 0; i < req_dat_n; i++)
         if (data_q.size() > 0) void'(data_q.pop_front());
      req_flag_pop = 0;
      req_dat_n    = 0;
      drive_fifo();
   end

   // Monitor: pop safety, pop offsets, stall stability and beat scoreboard.
   always @(negedge clk) begin
      beat_t b;
      cyc++;
      if (rst_n && !Reset) begin
         if (flag_pop) begin
            check("flag_pop_when_empty", flag_empty, 0);
            last_flag_pop_cyc = cyc;
         end
         if (dat_pop) begin
            check("pop_safety", (dat_pop_offset >= 1) && (dat_pop_offset <= dat_count), 1);
            if (pop_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_pop: offset %0d, expected no pop (cycle %0d)", dat_pop_offset, cyc);
            end else begin
               check("pop_offset", dat_pop_offset, pop_q.pop_front());
            end
            total_popped += int'(dat_pop_offset);
            last_dat_pop_cyc = cyc;
         end else begin
            check("offset_idle_zero", dat_pop_offset, 0);
         end
         if (stall_prev) begin
            check("stall_valid_held", out_valid, 1);
            check("stall_data_held", out_data, prev_data);
            check("stall_last_held", out_last, prev_last);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_beat: data %0h, expected no beat (cycle %0d)", out_data, cyc);
            end else begin
               b = exp_q.pop_front();
               check("beat_data", out_data, b.data);
               check("beat_last", out_last, b.last);
               if (b.first) first_beat_cyc = cyc;
            end
            beats_seen++;
         end
         stall_prev   = out_valid && !out_ready;
         prev_data    = out_data;
         prev_last    = out_last;
         req_flag_pop = flag_pop;
         req_dat_n    = dat_pop ? int'(dat_pop_offset) : 0;
      end else begin
         check("reset_flag_pop", flag_pop, 0);
         check("reset_dat_pop", dat_pop, 0);
         stall_prev   = 0;
         req_flag_pop = 0;
         req_dat_n    = 0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
      case (ready_mode)
         0: out_ready = 1'b1;
         1: begin
            out_ready = (ready_ph % 3 == 0);
            ready_ph++;
         end
         default: begin
            out_ready = ($urandom_range(0, 9) < 7);
            count_cap = $urandom_range(1, 16);
         end
      endcase
   endtask

   task automatic wait_drain(input string name, input int bound);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || pop_q.size() != 0 || flag_q.size() != 0) && n < bound) begin
         tick();
         n++;
      end
      check({"drain_", name}, n < bound, 1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0, b0, rel, n;
      logic [FW-1:0] f;
      rst_n     = 1'b0;
      Reset     = 1'b0;
      out_ready = 1'b1;
      dat_win   = '0;
      dat_count = '0;
      flag_data = '0;
      flag_empty = 1'b1;

      // Dense word queued before reset release: no pop may happen in reset.
      fixed_d.delete();
      for (int i = 1; i <= 16; i++) fixed_d.push_back(DW'(i));
      push_word(16'hFFFF, 1);
      drive_fifo();
      #1;
      check("reset_out_valid", out_valid, 0);
      check("reset_out_last", out_last, 0);
      check("reset_out_data", out_data, 0);
      check("reset_flag_pop_async", flag_pop, 0);
      check("reset_offset", dat_pop_offset, 0);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;

      p0 = total_popped;
      wait_drain("dense", 100);
      check("dense_latency", first_beat_cyc - last_flag_pop_cyc, 2);
      check("dense_popped", total_popped - p0, 16);

      fixed_d = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
      push_word(16'h8421, 1);
      wait_drain("sparse", 100);

      fixed_d = '{8'h05, 8'h06, 8'h07, 8'h08};
      push_word(16'h00F0, 1);
      wait_drain("zero_chunks", 100);

      // Starvation: only two entries visible while the chunk needs four.
      count_cap = 2;
      p0 = total_popped;
      b0 = beats_seen;
      push_word(16'h000F, 0);
      repeat (8) tick();
      check("starve_flag_taken", flag_q.size(), 0);
      check("starve_no_pop", total_popped - p0, 0);
      check("starve_no_beat", beats_seen - b0, 0);
      count_cap = 1000;
      rel = cyc;
      wait_drain("starve", 100);
      check("starve_release_cycle", last_dat_pop_cyc - rel, 2);

      // Backpressure with a 1,0,0 ready pattern.
      ready_mode = 1;
      p0 = total_popped;
      push_word(16'hFFFF, 0);
      wait_drain("backpressure", 200);
      check("bp_popped", total_popped - p0, 16);
      ready_mode = 0;
      tick();

      // Mid-word synchronous reset after the second beat is accepted.
      b0 = beats_seen;
      push_word(16'hFFFF, 0);
      n = 0;
      while (beats_seen < b0 + 2 && n < 50) begin
         tick();
         n++;
      end
      check("midreset_reach_beat2", n < 50, 1);
      Reset = 1'b1;
      exp_q.delete();
      pop_q.delete();
      data_q.delete();
      flag_q.delete();
      tick();
      Reset = 1'b0;
      @(negedge clk);
      #1;
      check("midreset_valid_cleared", out_valid, 0);
      check("midreset_last_cleared", out_last, 0);
      p0 = total_popped;
      repeat (5) tick();
      check("midreset_no_pop", total_popped - p0, 0);
      fixed_d = '{8'h11, 8'h22, 8'h33, 8'h44};
      push_word(16'h8421, 1);
      wait_drain("after_reset", 100);

      // Randomised words with random readiness and FIFO visibility.
      ready_mode = 2;
      for (int w = 0; w < 40; w++) begin
         f = FW'($urandom);
         for (int c = 0; c < CH; c++)
            if ($urandom_range(0, 3) == 0) f[c*L +: L] = '0;
         push_word(f, 0);
         n = 0;
         while (flag_q.size() != 0 && n < 200) begin
            tick();
            n++;
         end
         check("random_flag_taken", n < 200, 1);
      end
      wait_drain("random", 2000);
      ready_mode = 0;
      count_cap  = 1000;
      repeat (4) tick();
      check("final_exp_empty", exp_q.size(), 0);
      check("final_data_empty", data_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
